// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory and loads the IF/ID register.
// Optional performance counters are compiled in with `define IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter int               PC_W        = 32,
  parameter logic [PC_W-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [INS_W-1:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_W-1:0]        redirect_pc,
  output logic [INS_ADDRESS-1:0] imem_addr,
  input  logic [INS_W-1:0]       imem_rdata,
  output logic [PC_W-1:0]        id_pc,
  output logic [INS_W-1:0]       id_instr,
  output logic                   id_valid,
  output logic [PC_W-1:0]        pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_bubbles
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP    = {{(PC_W-3){1'b0}}, 3'b100};
  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  id_pc_q, id_pc_d;
  logic [INS_W-1:0] id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;

  // Address comes straight from the registered PC, so stall/redirect never reach imem_addr combinationally.
  assign imem_addr = pc_q[INS_ADDRESS-1:0];
  assign pc        = pc_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        id_valid_d = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          // Redirect wins over stall: the fetched word belongs to the wrong path, so squash it.
          pc_d       = redirect_pc & ALIGN_MASK;
          id_pc_d    = '0;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          pc_d       = pc_q + PC_STEP;
          id_pc_d    = pc_q;
          id_instr_d = imem_rdata;
          id_valid_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic        fetch_evt, bubble_evt;

  assign fetch_evt  = (state_q == RUN) && !redirect && !stall;
  assign bubble_evt = (state_q == RUN) && (redirect || stall);

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (fetch_evt)  perf_fetched_d = perf_fetched_q + 32'd1;
    if (bubble_evt) perf_bubbles_d = perf_bubbles_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
